// File: rtl/mips_cpu_alu_core.sv
// Datapath ALU for the multi-cycle MIPS CPU: combinational result/branch condition,
// plus HI/LO registers updated on the rising edge by MULT(U)/DIV(U)/MTHI/MTLO.
module mips_cpu_alu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  alu_func,
  input  logic [2:0]  mult_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shift,
  input  logic        write,
  output logic        condition,
  output logic [31:0] result
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_sden;
  logic [31:0] w_uden;
  logic [31:0] w_mq;
  logic [31:0] w_mr;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_diff;
  logic        w_a_neg;
  logic        w_a_zero;

  assign w_mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_mul_u = {32'd0, a} * {32'd0, b};

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_abs_a = a[31] ? (32'd0 - a) : a;
  assign w_abs_b = b[31] ? (32'd0 - b) : b;
  assign w_sden  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_uden  = (b == 32'd0) ? 32'd1 : b;
  assign w_mq    = w_abs_a / w_sden;
  assign w_mr    = w_abs_a % w_sden;
  assign w_sq    = (a[31] ^ b[31]) ? (32'd0 - w_mq) : w_mq;
  assign w_sr    = a[31] ? (32'd0 - w_mr) : w_mr;
  assign w_uq    = a / w_uden;
  assign w_ur    = a % w_uden;

  assign w_diff   = a - b;
  assign w_a_neg  = a[31];
  assign w_a_zero = (a == 32'd0);

  always_comb begin
    result    = 32'd0;
    condition = 1'b0;
    case (alu_func)
      5'd0:  result = a + b;
      5'd1:  result = w_diff;
      5'd2:  result = a & b;
      5'd3:  result = a | b;
      5'd4:  result = a ^ b;
      5'd5:  result = ~(a | b);
      5'd6:  result = {31'd0, $signed(a) < $signed(b)};
      5'd7:  result = {31'd0, a < b};
      5'd8:  result = b << shift;
      5'd9:  result = b >> shift;
      5'd10: result = $unsigned($signed(b) >>> shift);
      5'd11: result = b << a[4:0];
      5'd12: result = b >> a[4:0];
      5'd13: result = $unsigned($signed(b) >>> a[4:0]);
      5'd14: result = {b[15:0], 16'd0};
      5'd15: result = r_hi;
      5'd16: result = r_lo;
      5'd17: begin result = w_diff; condition = (a == b); end
      5'd18: begin result = w_diff; condition = (a != b); end
      5'd19: begin result = w_diff; condition = w_a_neg | w_a_zero; end
      5'd20: begin result = w_diff; condition = ~w_a_neg & ~w_a_zero; end
      5'd21: begin result = w_diff; condition = w_a_neg; end
      5'd22: begin result = w_diff; condition = ~w_a_neg; end
      5'd23: result = a;
      default: result = 32'd0;
    endcase
  end

  // Divide by zero leaves HI/LO untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (write) begin
      case (mult_op)
        3'd1: begin r_hi <= w_mul_s[63:32]; r_lo <= w_mul_s[31:0]; end
        3'd2: begin r_hi <= w_mul_u[63:32]; r_lo <= w_mul_u[31:0]; end
        3'd3: if (b != 32'd0) begin r_hi <= w_sr; r_lo <= w_sq; end
        3'd4: if (b != 32'd0) begin r_hi <= w_ur; r_lo <= w_uq; end
        3'd5: r_hi <= a;
        3'd6: r_lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_alu_core.sv
// Bench for mips_cpu_alu_core: directed corner cases then randomized ops against a reference model.
module tb_mips_cpu_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  alu_func;
  logic [2:0]  mult_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shift;
  logic        write;
  logic        condition;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  bit [31:0] m_hi = 32'd0;
  bit [31:0] m_lo = 32'd0;

  mips_cpu_alu_core dut (
    .clk(clk), .reset(reset), .alu_func(alu_func), .mult_op(mult_op),
    .a(a), .b(b), .shift(shift), .write(write),
    .condition(condition), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_out(input int f, input bit [31:0] ua, input bit [31:0] ub,
                                    input int sh, output bit [31:0] res, output bit cond);
    int sa = int'(ua);
    int sb = int'(ub);
    res = 0;
    cond = 0;
    case (f)
      0: res = ua + ub;
      1: res = ua - ub;
      2: res = ua & ub;
      3: res = ua | ub;
      4: res = ua ^ ub;
      5: res = ~(ua | ub);
      6: res = (sa < sb) ? 1 : 0;
      7: res = (ua < ub) ? 1 : 0;
      8: res = ub << sh;
      9: res = ub >> sh;
      10: res = sb >>> sh;
      11: res = ub << (ua % 32);
      12: res = ub >> (ua % 32);
      13: res = sb >>> (ua % 32);
      14: res = ub * 65536;
      15: res = m_hi;
      16: res = m_lo;
      23: res = ua;
      default: res = 0;
    endcase
    if (f >= 17 && f <= 22) begin
      res = ua - ub;
      case (f)
        17: cond = (ua == ub);
        18: cond = (ua != ub);
        19: cond = (sa <= 0);
        20: cond = (sa > 0);
        21: cond = (sa < 0);
        default: cond = (sa >= 0);
      endcase
    end
  endfunction

  function automatic void model_edge(input bit rst, input bit wr, input int op,
                                     input bit [31:0] ua, input bit [31:0] ub);
    longint p;
    longint unsigned pu;
    longint q;
    longint r;
    if (rst) begin
      m_hi = 0; m_lo = 0;
    end else if (wr) begin
      case (op)
        1: begin p = longint'(int'(ua)) * longint'(int'(ub)); m_hi = p[63:32]; m_lo = p[31:0]; end
        2: begin pu = longint'(ua) * longint'(ub); m_hi = pu[63:32]; m_lo = pu[31:0]; end
        3: if (ub != 0) begin
             q = longint'(int'(ua)) / longint'(int'(ub));
             r = longint'(int'(ua)) % longint'(int'(ub));
             m_lo = q[31:0]; m_hi = r[31:0];
           end
        4: if (ub != 0) begin m_lo = ua / ub; m_hi = ua % ub; end
        5: m_hi = ua;
        6: m_lo = ua;
        default: ;
      endcase
    end
  endfunction

  // Drive one cycle, check combinational outputs against the model, then clock it.
  task automatic run_cycle(input string tag, input bit rst, input int f, input int op,
                           input bit [31:0] ua, input bit [31:0] ub, input int sh, input bit wr);
    bit [31:0] er;
    bit ec;
    reset = rst; alu_func = f[4:0]; mult_op = op[2:0]; a = ua; b = ub;
    shift = sh[4:0]; write = wr;
    #1;
    model_out(f, ua, ub, sh, er, ec);
    check({tag, ".result"}, result, er);
    check({tag, ".cond"}, {31'd0, condition}, {31'd0, ec});
    @(posedge clk);
    model_edge(rst, wr, op, ua, ub);
    #1;
  endtask

  task automatic expect_out(input string tag, input int f, input bit [31:0] ua, input bit [31:0] ub,
                            input int sh, input bit [31:0] er, input bit ec);
    reset = 0; alu_func = f[4:0]; mult_op = 0; a = ua; b = ub; shift = sh[4:0]; write = 0;
    #1;
    check({tag, ".result"}, result, er);
    check({tag, ".cond"}, {31'd0, condition}, {31'd0, ec});
  endtask

  initial begin
    reset = 1; alu_func = 0; mult_op = 0; a = 0; b = 0; shift = 0; write = 0;
    @(posedge clk); #1;
    run_cycle("rst", 1, 0, 0, 0, 0, 0, 0);
    expect_out("rst_hi", 15, 0, 0, 0, 32'h0, 0);
    expect_out("rst_lo", 16, 0, 0, 0, 32'h0, 0);

    expect_out("add_wrap", 0, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
    expect_out("slt", 6, 32'hFFFFFFFF, 1, 0, 32'h1, 0);
    expect_out("sltu", 7, 32'hFFFFFFFF, 1, 0, 32'h0, 0);
    expect_out("sra", 10, 0, 32'h80000000, 4, 32'hF8000000, 0);
    expect_out("srlv", 12, 36, 32'h80000000, 0, 32'h08000000, 0);
    expect_out("blez0", 19, 0, 0, 0, 32'h0, 1);
    expect_out("bgtz0", 20, 0, 0, 0, 32'h0, 0);
    expect_out("bne_eq", 18, 5, 5, 0, 32'h0, 0);
    expect_out("or_cond", 3, 5, 5, 0, 32'h5, 0);
    expect_out("lui", 14, 0, 32'h0000ABCD, 0, 32'hABCD0000, 0);

    run_cycle("mult", 0, 0, 1, 32'hFFFFFFFD, 7, 0, 1);
    expect_out("mult_hi", 15, 0, 0, 0, 32'hFFFFFFFF, 0);
    expect_out("mult_lo", 16, 0, 0, 0, 32'hFFFFFFEB, 0);
    run_cycle("multu", 0, 0, 2, 32'hFFFFFFFF, 2, 0, 1);
    expect_out("multu_hi", 15, 0, 0, 0, 32'h1, 0);
    expect_out("multu_lo", 16, 0, 0, 0, 32'hFFFFFFFE, 0);
    run_cycle("div", 0, 0, 3, 32'hFFFFFFF9, 2, 0, 1);
    expect_out("div_lo", 16, 0, 0, 0, 32'hFFFFFFFD, 0);
    expect_out("div_hi", 15, 0, 0, 0, 32'hFFFFFFFF, 0);
    run_cycle("divu0", 0, 0, 4, 32'h12345678, 0, 0, 1);
    expect_out("divu0_lo", 16, 0, 0, 0, 32'hFFFFFFFD, 0);
    expect_out("divu0_hi", 15, 0, 0, 0, 32'hFFFFFFFF, 0);
    run_cycle("divovf", 0, 0, 3, 32'h80000000, 32'hFFFFFFFF, 0, 1);
    expect_out("divovf_lo", 16, 0, 0, 0, 32'h80000000, 0);
    expect_out("divovf_hi", 15, 0, 0, 0, 32'h0, 0);
    // MFHI in the same cycle as MTHI sees the old HI.
    run_cycle("mthi_bypass", 0, 15, 5, 32'h1234, 0, 0, 1);
    expect_out("mthi", 15, 0, 0, 0, 32'h1234, 0);
    run_cycle("rst_pri", 1, 0, 5, 32'h5555, 0, 0, 1);
    expect_out("rst_pri_hi", 15, 0, 0, 0, 32'h0, 0);
    run_cycle("mthi2", 0, 0, 5, 32'h55, 0, 0, 1);
    run_cycle("nowrite", 0, 0, 5, 32'h99, 0, 0, 0);
    expect_out("nowrite_hi", 15, 0, 0, 0, 32'h55, 0);

    for (int i = 0; i < 400; i++) begin
      bit [31:0] ra;
      bit [31:0] rb;
      int sel;
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) rb = 0;
      else if (sel == 1) rb = $urandom_range(0, 9);
      else if (sel == 2) ra = $urandom_range(0, 3) == 0 ? 32'h0 : (rb ^ ($urandom_range(0, 1) ? 32'h0 : 32'h1));
      run_cycle("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 31), $urandom_range(0, 7),
                ra, rb, $urandom_range(0, 31), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
